// File: rtl/tile_binner_if.sv
// Triangle-in / tile-beat-out bus for the raster front end.
// The master side is upstream and also plays the raster stage; the slave side is the binner.
interface tile_binner_if;
  localparam int unsigned VERTEX_W = 28;
  localparam int unsigned META_W   = 16;
  localparam int unsigned COLOR_W  = 4;

  logic                tri_vld;
  logic                tri_rdy;
  logic [VERTEX_W-1:0] tri_v0;
  logic [VERTEX_W-1:0] tri_v1;
  logic [VERTEX_W-1:0] tri_v2;
  logic [COLOR_W-1:0]  tri_color;
  logic                ready_in;
  logic                vld_out;
  logic [VERTEX_W-1:0] v0_out;
  logic [VERTEX_W-1:0] v1_out;
  logic [VERTEX_W-1:0] v2_out;
  logic [META_W-1:0]   metadata;
  logic                busy;

  modport slave (
    input  tri_vld, tri_v0, tri_v1, tri_v2, tri_color, ready_in,
    output tri_rdy, vld_out, v0_out, v1_out, v2_out, metadata, busy
  );

  modport master (
    output tri_vld, tri_v0, tri_v1, tri_v2, tri_color, ready_in,
    input  tri_rdy, vld_out, v0_out, v1_out, v2_out, metadata, busy
  );
endinterface

// File: rtl/tile_binner.sv
// Bins one screen-space triangle into the 32x32 tiles its clamped bounding box covers,
// emitting one vertex+metadata beat per tile in row-major order.
module tile_binner #(
  parameter int unsigned TILE_SHIFT   = 5,
  parameter int unsigned TILE_COLUMNS = 20,
  parameter int unsigned TILE_ROWS    = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  tile_binner_if.slave bus
);
  localparam int unsigned VERTEX_W = 28;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOR_W  = 4;
  localparam int unsigned TX_W     = 5;
  localparam int unsigned TY_W     = 4;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'((TILE_COLUMNS << TILE_SHIFT) - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'((TILE_ROWS << TILE_SHIFT) - 1);

  typedef enum logic [1:0] {IDLE, BBOX, EMIT} state_t;

  state_t               state_q, state_d;
  logic [VERTEX_W-1:0]  v0_q, v1_q, v2_q;
  logic [COLOR_W-1:0]   color_q;
  logic [TX_W-1:0]      tx_q, tx_lo_q, tx_hi_q;
  logic [TY_W-1:0]      ty_q, ty_hi_q;

  logic [COORD_W-1:0]   x0, x1, x2, y0, y1, y2;
  logic [COORD_W-1:0]   min_x, max_x, min_y, max_y, clamp_x, clamp_y;
  logic                 offscreen, accept, beat_done, last_tile, load_tiles;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Vertex layout is {x, y, z}; z only passes through to the raster stage.
  assign x0 = v0_q[27:18];
  assign x1 = v1_q[27:18];
  assign x2 = v2_q[27:18];
  assign y0 = v0_q[17:8];
  assign y1 = v1_q[17:8];
  assign y2 = v2_q[17:8];

  assign min_x     = min3(x0, x1, x2);
  assign max_x     = max3(x0, x1, x2);
  assign min_y     = min3(y0, y1, y2);
  assign max_y     = max3(y0, y1, y2);
  assign clamp_x   = (max_x > X_LAST) ? X_LAST : max_x;
  assign clamp_y   = (max_y > Y_LAST) ? Y_LAST : max_y;
  assign offscreen = (min_x > X_LAST) || (min_y > Y_LAST);

  assign accept    = bus.tri_vld && (state_q == IDLE);
  assign beat_done = (state_q == EMIT) && bus.ready_in;
  assign last_tile = (tx_q == tx_hi_q) && (ty_q == ty_hi_q);

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    load_tiles = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = BBOX;
      BBOX: begin
        if (offscreen) begin
          state_d = IDLE;
        end else begin
          state_d    = EMIT;
          load_tiles = 1'b1;
        end
      end
      EMIT: if (beat_done && last_tile) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Triangle capture and tile walk; x advances first, then wraps to the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      color_q <= '0;
      tx_q    <= '0;
      tx_lo_q <= '0;
      tx_hi_q <= '0;
      ty_q    <= '0;
      ty_hi_q <= '0;
    end else begin
      if (accept) begin
        v0_q    <= bus.tri_v0;
        v1_q    <= bus.tri_v1;
        v2_q    <= bus.tri_v2;
        color_q <= bus.tri_color;
      end
      if (load_tiles) begin
        tx_q    <= TX_W'(min_x >> TILE_SHIFT);
        tx_lo_q <= TX_W'(min_x >> TILE_SHIFT);
        tx_hi_q <= TX_W'(clamp_x >> TILE_SHIFT);
        ty_q    <= TY_W'(min_y >> TILE_SHIFT);
        ty_hi_q <= TY_W'(clamp_y >> TILE_SHIFT);
      end else if (beat_done && !last_tile) begin
        if (tx_q == tx_hi_q) begin
          tx_q <= tx_lo_q;
          ty_q <= ty_q + TY_W'(1);
        end else begin
          tx_q <= tx_q + TX_W'(1);
        end
      end
    end
  end

  assign bus.tri_rdy  = (state_q == IDLE);
  assign bus.vld_out  = (state_q == EMIT);
  assign bus.busy     = (state_q != IDLE);
  assign bus.v0_out   = v0_q;
  assign bus.v1_out   = v1_q;
  assign bus.v2_out   = v2_q;
  assign bus.metadata = {color_q, 3'b000, ty_q, tx_q};
endmodule
